apple_spawn_ctrl: RTL and testbench

Sequencer that places a new apple on a free grid cell. On a spawn request it samples a random candidate from the shared random-point generator, range-checks it, then walks every snake body segment through the body-memory read port and rejects the candidate if any segment occupies it. It retries up to a fixed limit, then commits the position. It sits between the game FSM (request/done handshake) and the VGA renderer / eat-detect logic (apple position).

---
 rtl/snake_pkg.sv | 38 +++
 rtl/apple_spawn_ctrl_if.sv | 30 +++
 rtl/apple_body_scanner.sv | 47 ++++
 rtl/apple_spawn_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_apple_spawn_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared snake-game constants and types used by the apple spawn logic.
package snake_pkg;

    localparam int unsigned COORD_W         = 5;
    localparam int unsigned H_LOGIC_MAX_DEF = 31;
    localparam int unsigned V_LOGIC_MAX_DEF = 23;
    localparam int unsigned LEN_WIDTH_DEF   = 10;
    localparam int unsigned TRY_W           = 8;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } point_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_SCAN,
        ST_DRAIN,
        ST_COMMIT
    } spawn_state_t;

    // Next cell of the raster sweep; an out-of-range row snaps back to row 0.
    function automatic point_t sweep_step(point_t p, coord_t h_max, coord_t v_max);
        point_t n;
        if (p.x >= h_max) begin
            n.x = '0;
            n.y = (p.y >= v_max) ? '0 : p.y + COORD_W'(1);
        end else begin
            n.x = p.x + COORD_W'(1);
            n.y = (p.y > v_max) ? '0 : p.y;
        end
        return n;
    endfunction

endpackage

// File: rtl/apple_spawn_ctrl_if.sv
// Spawn controller bus: game FSM handshake, random source, body-memory read port, apple position.
interface apple_spawn_ctrl_if #(
    parameter int unsigned LEN_WIDTH = snake_pkg::LEN_WIDTH_DEF
);

    logic                   spawn_req;
    snake_pkg::coord_t      rand_x;
    snake_pkg::coord_t      rand_y;
    logic [LEN_WIDTH-1:0]   length;
    logic                   body_rd;
    logic [LEN_WIDTH-1:0]   body_addr;
    snake_pkg::coord_t      body_x;
    snake_pkg::coord_t      body_y;
    snake_pkg::coord_t      apple_x;
    snake_pkg::coord_t      apple_y;
    logic                   busy;
    logic                   spawn_done;
    logic                   spawn_fail;

    modport master (
        output spawn_req, rand_x, rand_y, length, body_x, body_y,
        input  body_rd, body_addr, apple_x, apple_y, busy, spawn_done, spawn_fail
    );

    modport slave (
        input  spawn_req, rand_x, rand_y, length, body_x, body_y,
        output body_rd, body_addr, apple_x, apple_y, busy, spawn_done, spawn_fail
    );

endinterface

// File: rtl/apple_body_scanner.sv
// Body scanner: issues segment reads 0..len-1 and flags a candidate match one cycle after each read.
module apple_body_scanner
    import snake_pkg::*;
#(
    parameter int unsigned LEN_WIDTH = LEN_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_c,
    input  logic                 abort_c,
    input  logic [LEN_WIDTH-1:0] len,
    input  point_t               cand,
    input  coord_t               body_x,
    input  coord_t               body_y,
    output logic                 body_rd,
    output logic [LEN_WIDTH-1:0] body_addr,
    output logic                 last_c,
    output logic                 hit_c
);

    logic rd_vld;

    assign last_c = body_rd && (body_addr == len - LEN_WIDTH'(1));
    assign hit_c  = rd_vld && (body_x == cand.x) && (body_y == cand.y);

    // Address counter plus one-cycle read-valid pipeline; an abort squashes the read in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            body_rd   <= 1'b0;
            body_addr <= '0;
            rd_vld    <= 1'b0;
        end else begin
            rd_vld <= body_rd && !abort_c;
            if (start_c) begin
                body_rd   <= 1'b1;
                body_addr <= '0;
            end else if (body_rd) begin
                if (abort_c || last_c) begin
                    body_rd <= 1'b0;
                end else begin
                    body_addr <= body_addr + LEN_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/apple_spawn_ctrl.sv
// Apple spawn sequencer: samples random cells, rejects those on the snake body, commits a free one.
// Build option APPLE_SPAWN_FALLBACK_EN: on exhaustion, sweep the grid linearly instead of failing.
module apple_spawn_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned H_LOGIC_MAX = H_LOGIC_MAX_DEF,
    parameter int unsigned V_LOGIC_MAX = V_LOGIC_MAX_DEF,
    parameter int unsigned LEN_WIDTH   = LEN_WIDTH_DEF,
    parameter int unsigned MAX_TRIES   = 16,
    parameter int unsigned RST_X       = 15,
    parameter int unsigned RST_Y       = 15
) (
    input  logic              clk,
    input  logic              rst,
    apple_spawn_ctrl_if.slave bus
);

    localparam coord_t             H_LIM   = COORD_W'(H_LOGIC_MAX);
    localparam coord_t             V_LIM   = COORD_W'(V_LOGIC_MAX);
    localparam coord_t             APPLE_X0 = COORD_W'(RST_X);
    localparam coord_t             APPLE_Y0 = COORD_W'(RST_Y);
    localparam logic [TRY_W-1:0]   TRY_LIM = TRY_W'(MAX_TRIES);

`ifdef APPLE_SPAWN_FALLBACK_EN
    localparam int unsigned        CELLS     = (H_LOGIC_MAX + 1) * (V_LOGIC_MAX + 1);
    localparam int unsigned        SWEEP_W   = $clog2(CELLS + 1);
    localparam logic [SWEEP_W-1:0] SWEEP_LIM = SWEEP_W'(CELLS);

    logic               sweep, sweep_nxt;
    logic [SWEEP_W-1:0] sweep_cnt, sweep_cnt_nxt;
`endif

    spawn_state_t         state, state_nxt;
    logic [LEN_WIDTH-1:0] len_q, len_nxt;
    logic [TRY_W-1:0]     try_cnt, try_nxt;
    point_t               cand, cand_nxt;
    point_t               apple, apple_nxt;
    logic                 busy, busy_nxt;
    logic                 done, done_nxt;
    logic                 fail, fail_nxt;
    logic                 scan_start_c, reject_c, abort_c, hit_c, last_c;

    assign abort_c = (state == ST_SCAN) && hit_c;

    apple_body_scanner #(
        .LEN_WIDTH (LEN_WIDTH)
    ) u_scanner (
        .clk       (clk),
        .rst       (rst),
        .start_c   (scan_start_c),
        .abort_c   (abort_c),
        .len       (len_q),
        .cand      (cand),
        .body_x    (bus.body_x),
        .body_y    (bus.body_y),
        .body_rd   (bus.body_rd),
        .body_addr (bus.body_addr),
        .last_c    (last_c),
        .hit_c     (hit_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_nxt    = state;
        len_nxt      = len_q;
        try_nxt      = try_cnt;
        cand_nxt     = cand;
        apple_nxt    = apple;
        done_nxt     = 1'b0;
        fail_nxt     = 1'b0;
        scan_start_c = 1'b0;
        reject_c     = 1'b0;
`ifdef APPLE_SPAWN_FALLBACK_EN
        sweep_nxt     = sweep;
        sweep_cnt_nxt = sweep_cnt;
`endif

        case (state)
            ST_IDLE: begin
                if (bus.spawn_req && !busy) begin
                    len_nxt   = bus.length;
                    try_nxt   = '0;
                    state_nxt = ST_SAMPLE;
`ifdef APPLE_SPAWN_FALLBACK_EN
                    sweep_nxt = 1'b0;
`endif
                end
            end
            ST_SAMPLE: begin
`ifdef APPLE_SPAWN_FALLBACK_EN
                if (sweep) begin
                    cand_nxt      = sweep_step(cand, H_LIM, V_LIM);
                    sweep_cnt_nxt = sweep_cnt + SWEEP_W'(1);
                end else begin
                    cand_nxt = point_t'({bus.rand_x, bus.rand_y});
                    try_nxt  = try_cnt + TRY_W'(1);
                end
`else
                cand_nxt = point_t'({bus.rand_x, bus.rand_y});
                try_nxt  = try_cnt + TRY_W'(1);
`endif
                if ((cand_nxt.x > H_LIM) || (cand_nxt.y > V_LIM)) begin
                    reject_c = 1'b1;
                end else if (len_q == '0) begin
                    state_nxt = ST_COMMIT;
                end else begin
                    scan_start_c = 1'b1;
                    state_nxt    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (hit_c) begin
                    reject_c = 1'b1;
                end else if (last_c) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (hit_c) begin
                    reject_c = 1'b1;
                end else begin
                    state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                apple_nxt = cand;
                done_nxt  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Rejected candidate: retry, fall back to the sweep, or give up.
        if (reject_c) begin
`ifdef APPLE_SPAWN_FALLBACK_EN
            if (sweep) begin
                if (sweep_cnt_nxt < SWEEP_LIM) begin
                    state_nxt = ST_SAMPLE;
                end else begin
                    fail_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end else if (try_nxt < TRY_LIM) begin
                state_nxt = ST_SAMPLE;
            end else begin
                sweep_nxt     = 1'b1;
                sweep_cnt_nxt = '0;
                state_nxt     = ST_SAMPLE;
            end
`else
            if (try_nxt < TRY_LIM) begin
                state_nxt = ST_SAMPLE;
            end else begin
                fail_nxt  = 1'b1;
                state_nxt = ST_IDLE;
            end
`endif
        end

        // Held through the done/fail pulse cycle so a request there is dropped.
        busy_nxt = (state_nxt != ST_IDLE) || (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            len_q   <= '0;
            try_cnt <= '0;
            cand    <= '0;
            apple   <= point_t'({APPLE_X0, APPLE_Y0});
            busy    <= 1'b0;
            done    <= 1'b0;
            fail    <= 1'b0;
`ifdef APPLE_SPAWN_FALLBACK_EN
            sweep     <= 1'b0;
            sweep_cnt <= '0;
`endif
        end else begin
            state   <= state_nxt;
            len_q   <= len_nxt;
            try_cnt <= try_nxt;
            cand    <= cand_nxt;
            apple   <= apple_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            fail    <= fail_nxt;
`ifdef APPLE_SPAWN_FALLBACK_EN
            sweep     <= sweep_nxt;
            sweep_cnt <= sweep_cnt_nxt;
`endif
        end
    end

    assign bus.apple_x    = apple.x;
    assign bus.apple_y    = apple.y;
    assign bus.busy       = busy;
    assign bus.spawn_done = done;
    assign bus.spawn_fail = fail;

endmodule

// File: tb/tb_apple_spawn_ctrl.sv
// Self-checking bench for apple_spawn_ctrl: scoreboard of expected spawn outcomes per request.
module tb_apple_spawn_ctrl;
    import snake_pkg::*;

    localparam int unsigned LW    = 10;
    localparam int unsigned TRIES = 4;
    localparam int          BOUND = 5000;

    typedef struct {
        logic fail;
        int   x;
        int   y;
        int   edge_n;
        int   reads;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    apple_spawn_ctrl_if #(.LEN_WIDTH(LW)) bus_if ();

    apple_spawn_ctrl #(
        .H_LOGIC_MAX (31),
        .V_LOGIC_MAX (23),
        .LEN_WIDTH   (LW),
        .MAX_TRIES   (TRIES),
        .RST_X       (15),
        .RST_Y       (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    coord_t mem_x [1024];
    coord_t mem_y [1024];
    int     rd_log [$];
    exp_t   exp_q [$];
    int     n_checks = 0;
    int     n_fail   = 0;

    // Body memory: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (bus_if.body_rd) begin
            bus_if.body_x <= mem_x[bus_if.body_addr];
            bus_if.body_y <= mem_y[bus_if.body_addr];
        end
    end

    always @(negedge clk) begin
        if (bus_if.body_rd) rd_log.push_back(int'(bus_if.body_addr));
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t mk_exp(logic f, int x, int y, int e, int r);
        exp_t t;
        t.fail = f; t.x = x; t.y = y; t.edge_n = e; t.reads = r;
        return t;
    endfunction

    task automatic set_snake4();
        for (int i = 0; i < 4; i++) begin
            mem_x[i] = COORD_W'(i + 1);
            mem_y[i] = COORD_W'(1);
        end
    endtask

    // One request: rand (x0,y0) sampled on edges before sw, (x1,y1) from edge sw on.
    task automatic do_spawn(input string name, input int len, input int x0, input int y0,
                            input int x1, input int y1, input int sw, input exp_t e);
        exp_t got_e;
        int   ed;
        bit   seen;
        exp_q.push_back(e);
        rd_log.delete();
        @(negedge clk);
        bus_if.length    = LW'(len);
        bus_if.rand_x    = COORD_W'(x0);
        bus_if.rand_y    = COORD_W'(y0);
        bus_if.spawn_req = 1'b1;
        @(posedge clk);
        ed   = 0;
        seen = 1'b0;
        while (!seen && ed < BOUND) begin
            @(negedge clk);
            bus_if.spawn_req = 1'b0;
            bus_if.length    = '0;
            if (ed + 1 >= sw) begin
                bus_if.rand_x = COORD_W'(x1);
                bus_if.rand_y = COORD_W'(y1);
            end
            if (bus_if.spawn_done || bus_if.spawn_fail) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                ed++;
            end
        end
        check_val({name, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            got_e = exp_q.pop_front();
            check_val({name, "_fail"},    32'(bus_if.spawn_fail), 32'(got_e.fail));
            check_val({name, "_apple_x"}, 32'(bus_if.apple_x), 32'(got_e.x));
            check_val({name, "_apple_y"}, 32'(bus_if.apple_y), 32'(got_e.y));
            check_val({name, "_edge"},    32'(ed), 32'(got_e.edge_n));
            check_val({name, "_reads"},   32'(rd_log.size()), 32'(got_e.reads));
            check_val({name, "_busy_pulse"}, 32'(bus_if.busy), 32'd1);
            bus_if.spawn_req = 1'b1;
            @(negedge clk);
            bus_if.spawn_req = 1'b0;
            check_val({name, "_busy_after"}, 32'(bus_if.busy), 32'd0);
            check_val({name, "_pulse_once"}, 32'(bus_if.spawn_done | bus_if.spawn_fail), 32'd0);
            repeat (3) @(negedge clk);
            check_val({name, "_ghost_ignored"}, 32'(bus_if.busy), 32'd0);
        end else begin
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        int idx;
        bit saw_done;
        rst              = 1'b0;
        bus_if.spawn_req = 1'b0;
        bus_if.rand_x    = '0;
        bus_if.rand_y    = '0;
        bus_if.length    = '0;
        for (int i = 0; i < 1024; i++) begin
            mem_x[i] = '0;
            mem_y[i] = 5'd31;
        end
        repeat (3) @(negedge clk);
        check_val("rst_apple_x", 32'(bus_if.apple_x), 32'd15);
        check_val("rst_apple_y", 32'(bus_if.apple_y), 32'd15);
        check_val("rst_busy",    32'(bus_if.busy), 32'd0);
        check_val("rst_done",    32'(bus_if.spawn_done), 32'd0);
        check_val("rst_fail",    32'(bus_if.spawn_fail), 32'd0);
        check_val("rst_body_rd", 32'(bus_if.body_rd), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        do_spawn("len0", 0, 7, 3, 7, 3, 1, mk_exp(1'b0, 7, 3, 2, 0));

        set_snake4();
        do_spawn("free4", 4, 10, 10, 10, 10, 1, mk_exp(1'b0, 10, 10, 7, 4));
        for (int i = 0; i < 4; i++) check_val("free4_addr", 32'(rd_log[i]), 32'(i));

        do_spawn("hit1", 4, 2, 1, 9, 9, 2, mk_exp(1'b0, 9, 9, 11, 7));

`ifdef APPLE_SPAWN_FALLBACK_EN
        mem_x[0] = 5'd31;
        mem_y[0] = 5'd4;
        idx = 1;
        for (int y = 0; y < 24; y++) begin
            for (int x = 0; x < 32; x++) begin
                if (!((x == 0 && y == 5) || (x == 31 && y == 4))) begin
                    mem_x[idx] = COORD_W'(x);
                    mem_y[idx] = COORD_W'(y);
                    idx++;
                end
            end
        end
        do_spawn("sweep", 767, 31, 4, 31, 4, 1, mk_exp(1'b0, 0, 5, 782, 775));
        set_snake4();
`else
        idx = 0;
        do_spawn("exhaust", 4, 3, 28, 3, 28, 1, mk_exp(1'b1, 9, 9, 4, 0));
`endif

        // Reset in the middle of a scan abandons the request.
        @(negedge clk);
        bus_if.length    = LW'(4);
        bus_if.rand_x    = 5'd10;
        bus_if.rand_y    = 5'd10;
        bus_if.spawn_req = 1'b1;
        @(negedge clk);
        bus_if.spawn_req = 1'b0;
        @(negedge clk);
        check_val("midscan_rd", 32'(bus_if.body_rd), 32'd1);
        rst = 1'b0;
        #1;
        check_val("arst_apple_x", 32'(bus_if.apple_x), 32'd15);
        check_val("arst_apple_y", 32'(bus_if.apple_y), 32'd15);
        check_val("arst_busy",    32'(bus_if.busy), 32'd0);
        check_val("arst_body_rd", 32'(bus_if.body_rd), 32'd0);
        check_val("arst_addr",    32'(bus_if.body_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus_if.spawn_done || bus_if.busy) saw_done = 1'b1;
        end
        check_val("arst_no_done", 32'(saw_done), 32'd0);
        check_val("arst_apple_hold", 32'(bus_if.apple_x), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
